// File: rtl/arbiter_rr_lease.sv
// 4-way round-robin arbiter with bounded grant lease; grant registered one edge after request.
// No backpressure: holder releases on done/drop/mask/expiry, followed by one dead GAP cycle.
module arbiter_rr_lease #(
    parameter int LEASE_MAX = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic [3:0] done_i,
    input  logic [3:0] mask_i,
    output logic [3:0] grant_o,
    output logic       grant_vld_o,
    output logic [1:0] grant_id_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       id_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] lease_cnt, lease_nxt;
    logic             to_nxt;

    logic [3:0]       ereq;
    logic             found;
    logic [1:0]       winner;
    logic             rel_other;
    logic             expired;

    assign ereq        = req_i & mask_i;
    assign grant_vld_o = |grant_o;

    // Search from ptr upward with 2-bit wrap so the last releaser gets lowest priority.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && ereq[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
                found  = 1'b1;
            end
        end
    end

    assign rel_other = done_i[grant_id_o] | ~req_i[grant_id_o] | ~mask_i[grant_id_o];
    assign expired   = (lease_cnt == CNT_W'(LEASE_MAX - 1));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        id_nxt    = grant_id_o;
        ptr_nxt   = ptr;
        lease_nxt = lease_cnt;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = 4'b0001 << winner;
                    id_nxt    = winner;
                    lease_nxt = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (rel_other || expired) begin
                    grant_nxt = 4'b0000;
                    ptr_nxt   = grant_id_o + 2'd1;
                    to_nxt    = expired && !rel_other;
                    state_nxt = GAP;
                end else begin
                    lease_nxt = lease_cnt + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 4'b0000;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_o    <= 4'b0000;
            grant_id_o <= 2'd0;
            timeout_o  <= 1'b0;
            ptr        <= 2'd0;
            lease_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            grant_o    <= grant_nxt;
            grant_id_o <= id_nxt;
            timeout_o  <= to_nxt;
            ptr        <= ptr_nxt;
            lease_cnt  <= lease_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_lease.sv
// Bench for arbiter_rr_lease: directed scenarios plus random traffic against a cycle-level model.
module tb_arbiter_rr_lease;

    localparam int LEASE_MAX = 16;
    localparam int CNT_W     = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_i = 4'b0;
    logic [3:0] done_i = 4'b0;
    logic [3:0] mask_i = 4'b0;
    logic [3:0] grant_o;
    logic       grant_vld_o;
    logic [1:0] grant_id_o;
    logic       timeout_o;

    int n_run  = 0;
    int n_fail = 0;

    arbiter_rr_lease #(.LEASE_MAX(LEASE_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .done_i(done_i), .mask_i(mask_i),
        .grant_o(grant_o), .grant_vld_o(grant_vld_o), .grant_id_o(grant_id_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Reference: who holds the resource, how long it has held it, whose turn is next.
    int m_holder;   // -1 when nobody holds
    int m_held;     // cycles the current holder has had the grant visible
    int m_ptr;
    int m_id;
    bit m_gap;
    bit m_to;

    function automatic void model_reset();
        m_holder = -1; m_held = 0; m_ptr = 0; m_id = 0; m_gap = 0; m_to = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic [3:0] d, input logic [3:0] m);
        bit early, lease_up;
        m_to = 0;
        if (m_holder >= 0) begin
            early    = d[m_holder] || !r[m_holder] || !m[m_holder];
            lease_up = (m_held == LEASE_MAX);
            if (early || lease_up) begin
                m_ptr    = (m_holder + 1) % 4;
                m_holder = -1;
                m_gap    = 1;
                m_to     = lease_up && !early;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_holder < 0 && r[(m_ptr + i) % 4] && m[(m_ptr + i) % 4]) begin
                    m_holder = (m_ptr + i) % 4;
                    m_id     = m_holder;
                    m_held   = 1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
        return {g, |g, 2'(m_id), m_to};
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] m);
        req_i = r; done_i = d; mask_i = m;
        @(posedge clk);
        model_edge(r, d, m);
        #1;
    endtask

    task automatic do_reset();
        req_i = 4'b0; done_i = 4'b0; mask_i = 4'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if ({grant_o, grant_vld_o, grant_id_o, timeout_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", {grant_o, grant_vld_o, grant_id_o, timeout_o}, 8'b0);
        end
        for (int c = 0; c < 4; c++) step(4'b1111, 4'b0, 4'b0000);
        n_run++;
        if (grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_all_masked: grant got %b want 0000", grant_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        step(4'b0001, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0001 || grant_id_o !== 2'd0 || grant_vld_o !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_first_grant: grant %b id %0d vld %b want 0001 0 1", grant_o, grant_id_o, grant_vld_o);
        end
        step(4'b0001, 4'b0, 4'b1111);
        step(4'b0001, 4'b0, 4'b1111);
        step(4'b0001, 4'b0001, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done_release: grant %b to %b want 0000 0", grant_o, timeout_o);
        end
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 4'b0, 4'b1111);
            n_run++;
            if ({grant_o, grant_vld_o, grant_id_o, timeout_o} !== model_out()) begin
                n_fail++;
                $display("FAIL t1_model c%0d: got %b want %b", c, {grant_o, grant_vld_o, grant_id_o, timeout_o}, model_out());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        logic [3:0] seq [$];
        int zeros;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        zeros = 0;
        do_reset();
        for (int c = 0; c < 60 && seq.size() < 5; c++) begin
            step(4'b1111, grant_o, 4'b1111);
            if (grant_o !== 4'b0000) begin
                if (seq.size() > 0) begin
                    n_run++;
                    if (zeros !== 2) begin
                        n_fail++;
                        $display("FAIL t2_spacing: zero cycles %0d want 2", zeros);
                    end
                end
                seq.push_back(grant_o);
                zeros = 0;
            end else begin
                zeros++;
            end
        end
        n_run++;
        if (seq.size() !== 5) begin
            n_fail++;
            $display("FAIL t2_count: grants seen %0d want 5", seq.size());
        end
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            n_run++;
            if (seq[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL t2_order[%0d]: got %b want %b", i, seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_lease_expiry();
        int hold;
        do_reset();
        step(4'b0100, 4'b0, 4'b1111);
        hold = (grant_o === 4'b0100) ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            step(4'b0100, 4'b0, 4'b1111);
            if (grant_o === 4'b0100 && timeout_o === 1'b0) hold++;
        end
        n_run++;
        if (hold !== LEASE_MAX) begin
            n_fail++;
            $display("FAIL t3_hold_len: held %0d cycles want %0d", hold, LEASE_MAX);
        end
        step(4'b0100, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0000 || timeout_o !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_expire: grant %b to %b want 0000 1", grant_o, timeout_o);
        end
        step(4'b0100, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_idle: grant %b to %b want 0000 0", grant_o, timeout_o);
        end
        step(4'b0100, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL t3_regrant: grant %b want 0100", grant_o);
        end
    endtask

    task automatic test_done_expiry();
        do_reset();
        step(4'b0100, 4'b0, 4'b1111);
        for (int c = 0; c < LEASE_MAX - 1; c++) step(4'b0100, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL t4_still_held: grant %b want 0100", grant_o);
        end
        step(4'b0100, 4'b0100, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_done_wins: grant %b to %b want 0000 0", grant_o, timeout_o);
        end
    endtask

    task automatic test_mask_revoke();
        do_reset();
        step(4'b0011, 4'b0, 4'b1111);
        step(4'b0011, 4'b0001, 4'b1111);
        step(4'b0011, 4'b0, 4'b1111);
        step(4'b0011, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0010 || grant_id_o !== 2'd1) begin
            n_fail++;
            $display("FAIL t5_unit1_holds: grant %b id %0d want 0010 1", grant_o, grant_id_o);
        end
        step(4'b0011, 4'b0, 4'b1111);
        step(4'b0011, 4'b0, 4'b1101);
        n_run++;
        if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_revoke: grant %b to %b want 0000 0", grant_o, timeout_o);
        end
        step(4'b0011, 4'b0, 4'b1111);
        step(4'b0011, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL t5_wrap_grant: grant %b want 0001", grant_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step(4'b1000, 4'b0, 4'b1111);
        step(4'b1000, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL t6_setup: grant %b want 1000", grant_o);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_run++;
        if ({grant_o, grant_vld_o, grant_id_o, timeout_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL t6_async_rst: got %b want %b", {grant_o, grant_vld_o, grant_id_o, timeout_o}, 8'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1111, 4'b0, 4'b1111);
        n_run++;
        if (grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL t6_ptr_reset: grant %b want 0001", grant_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] r, d, m;
        int bad;
        bad = 0;
        do_reset();
        r = 4'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom);
            d = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            m = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b1111;
            step(r, d, m);
            if ({grant_o, grant_vld_o, grant_id_o, timeout_o} !== model_out()) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_model c%0d: got %b want %b", c, {grant_o, grant_vld_o, grant_id_o, timeout_o}, model_out());
            end
        end
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_total: %0d mismatching cycles want 0", bad);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_lease_expiry();
        test_done_expiry();
        test_mask_revoke();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
